// File: rtl/adder_bist_checker_if.sv
// Bus between the BIST checker and its environment: the adder-under-test
// operand/result lines plus the run control and status lines.
interface adder_bist_checker_if;
   logic        start;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [32:0] fail_vec;
   logic [15:0] dut_a;
   logic [15:0] dut_b;
   logic        dut_cin;
   logic [15:0] dut_s;
   logic        dut_cout;

   modport master (
      input  start, dut_s, dut_cout,
      output busy, done, pass, err_count, fail_vec, dut_a, dut_b, dut_cin
   );

   modport slave (
      output start, dut_s, dut_cout,
      input  busy, done, pass, err_count, fail_vec, dut_a, dut_b, dut_cin
   );
endinterface

// File: rtl/adder_bist_checker.sv
// Built-in self-test for a 16-bit adder: drives LFSR operand pairs, checks sums.
// Define ADDER_BIST_CORNER_EN to prepend four fixed corner vectors to each run.
module adder_bist_checker #(
   parameter int unsigned NUM_VECTORS = 1024,
   parameter int unsigned SETTLE      = 2
) (
   input logic                  clk,
   input logic                  rst,
   adder_bist_checker_if.master bus
);

   localparam logic [15:0] SEED_A   = 16'hACE1;
   localparam logic [15:0] SEED_B   = 16'h1D2C;
   localparam logic [15:0] TAPS     = 16'hB400;
   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
   localparam int unsigned CNT_W    = $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

   typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [15:0]      lfsr_a_q, lfsr_a_d;
   logic [15:0]      lfsr_b_q, lfsr_b_d;
   logic [15:0]      idx_q, idx_d;
   logic [15:0]      a_q, a_d;
   logic [15:0]      b_q, b_d;
   logic             cin_q, cin_d;
   logic [15:0]      err_q, err_d;
   logic [32:0]      fail_q, fail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [16:0]      expected;
   logic             mismatch;

`ifdef ADDER_BIST_CORNER_EN
   logic       corner_q, corner_d;
   logic [1:0] cidx_q, cidx_d;

   function automatic logic [32:0] corner_vec(input logic [1:0] sel);
      case (sel)
         2'd0:    return {16'h0000, 16'h0000, 1'b0};
         2'd1:    return {16'hFFFF, 16'h0001, 1'b0};
         2'd2:    return {16'hFFFF, 16'hFFFF, 1'b1};
         default: return {16'h8000, 16'h8000, 1'b0};
      endcase
   endfunction
`endif

   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
   endfunction

   // NOTE: every always_comb output is given a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      lfsr_a_d = lfsr_a_q;
      lfsr_b_d = lfsr_b_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      cin_d    = cin_q;
      err_d    = err_q;
      fail_d   = fail_q;
      cnt_d    = cnt_q;
`ifdef ADDER_BIST_CORNER_EN
      corner_d = corner_q;
      cidx_d   = cidx_q;
`endif
      expected = {1'b0, a_q} + {1'b0, b_q} + 17'(cin_q);
      mismatch = ({bus.dut_cout, bus.dut_s} != expected);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d  = S_APPLY;
               err_d    = '0;
               fail_d   = '0;
               idx_d    = '0;
               lfsr_a_d = SEED_A;
               lfsr_b_d = SEED_B;
`ifdef ADDER_BIST_CORNER_EN
               corner_d = 1'b1;
               cidx_d   = '0;
`endif
            end
         end
         S_APPLY: begin
            {a_d, b_d, cin_d} = {lfsr_a_q, lfsr_b_q, idx_q[0]};
`ifdef ADDER_BIST_CORNER_EN
            if (corner_q) {a_d, b_d, cin_d} = corner_vec(cidx_q);
`endif
            cnt_d   = SETTLE_LD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_CHECK;
         end
         S_CHECK: begin
            // err_q never wraps, so zero identifies the first mismatch of the run
            if (mismatch) begin
               if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
               if (err_q == 16'd0) fail_d = {a_q, b_q, cin_q};
            end
            state_d = S_APPLY;
`ifdef ADDER_BIST_CORNER_EN
            if (corner_q) begin
               cidx_d   = cidx_q + 2'd1;
               corner_d = (cidx_q != 2'd3);
            end else begin
`endif
               lfsr_a_d = lfsr_step(lfsr_a_q);
               lfsr_b_d = lfsr_step(lfsr_b_q);
               idx_d    = idx_q + 16'd1;
               if (idx_q == LAST_IDX) state_d = S_DONE;
`ifdef ADDER_BIST_CORNER_EN
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         lfsr_a_q <= SEED_A;
         lfsr_b_q <= SEED_B;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         err_q    <= '0;
         fail_q   <= '0;
         cnt_q    <= '0;
`ifdef ADDER_BIST_CORNER_EN
         corner_q <= 1'b0;
         cidx_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         lfsr_a_q <= lfsr_a_d;
         lfsr_b_q <= lfsr_b_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cin_q    <= cin_d;
         err_q    <= err_d;
         fail_q   <= fail_d;
         cnt_q    <= cnt_d;
`ifdef ADDER_BIST_CORNER_EN
         corner_q <= corner_d;
         cidx_q   <= cidx_d;
`endif
      end
   end

   assign bus.busy      = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
   assign bus.done      = (state_q == S_DONE);
   assign bus.pass      = (state_q == S_DONE) && (err_q == 16'd0);
   assign bus.err_count = err_q;
   assign bus.fail_vec  = fail_q;
   assign bus.dut_a     = a_q;
   assign bus.dut_b     = b_q;
   assign bus.dut_cin   = cin_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Self-checking bench: behavioural adder with selectable faults, reference model
// of the expected vector list and run results, randomized run scheduling.
`timescale 1ns/1ps
module tb_adder_bist_checker;

   localparam int unsigned NV  = 16;
   localparam int unsigned ST  = 2;
   localparam int unsigned PER = ST + 2;
`ifdef ADDER_BIST_CORNER_EN
   localparam int unsigned NCORNER = 4;
`else
   localparam int unsigned NCORNER = 0;
`endif
   localparam int unsigned NTOT = NV + NCORNER;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   fault_mode = 0;
   int   fault_bit  = 0;

   adder_bist_checker_if bus();

   adder_bist_checker #(.NUM_VECTORS(NV), .SETTLE(ST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Adder under test: ideal sum, optionally corrupted.
   function automatic logic [16:0] apply_fault(input logic [16:0] t, input int mode, input int fbit);
      logic [16:0] r;
      r = t;
      case (mode)
         1: r[0] = 1'b0;
         2: r[16] = ~r[16];
         3: r[fbit[4:0]] = 1'b1;
         default: ;
      endcase
      return r;
   endfunction

   logic [16:0] true_sum, adder_out;
   assign true_sum     = {1'b0, bus.dut_a} + {1'b0, bus.dut_b} + 17'(bus.dut_cin);
   assign adder_out    = apply_fault(true_sum, fault_mode, fault_bit);
   assign bus.dut_s    = adder_out[15:0];
   assign bus.dut_cout = adder_out[16];

   // Reference model: the full vector list of a run and its expected outcome.
   logic [32:0] exp_vec[$];
   int unsigned exp_err;
   logic [32:0] exp_fail;

   task automatic build_model();
      logic [15:0] la, lb;
      logic [16:0] t;
      exp_vec.delete();
`ifdef ADDER_BIST_CORNER_EN
      exp_vec.push_back({16'h0000, 16'h0000, 1'b0});
      exp_vec.push_back({16'hFFFF, 16'h0001, 1'b0});
      exp_vec.push_back({16'hFFFF, 16'hFFFF, 1'b1});
      exp_vec.push_back({16'h8000, 16'h8000, 1'b0});
`endif
      la = 16'hACE1;
      lb = 16'h1D2C;
      for (int i = 0; i < int'(NV); i++) begin
         exp_vec.push_back({la, lb, 1'(i % 2)});
         la = (la >> 1) ^ ((la % 2 == 1) ? 16'hB400 : 16'h0000);
         lb = (lb >> 1) ^ ((lb % 2 == 1) ? 16'hB400 : 16'h0000);
      end
      exp_err  = 0;
      exp_fail = '0;
      foreach (exp_vec[i]) begin
         t = 17'(exp_vec[i][32:17]) + 17'(exp_vec[i][16:1]) + 17'(exp_vec[i][0]);
         if (apply_fault(t, fault_mode, fault_bit) != t) begin
            if (exp_err == 0) exp_fail = exp_vec[i];
            if (exp_err < 65535) exp_err++;
         end
      end
   endtask

   // Pulse start, follow the run to completion and compare against the model.
   task automatic run_and_check(input string name, input bit glitch);
      int          busy_cycles;
      int          k;
      int          vi;
      int          hold;
      bit          finished;
      logic [32:0] v;
      build_model();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s start: busy=%b done=%b, want busy=1 done=0", name, bus.busy, bus.done);
      end
      busy_cycles = 1;
      k           = 1;
      finished    = 1'b0;
      while (!finished && k < 4000) begin
         if (k >= 2 && (k - 2) % int'(PER) == 0 && (k - 2) / int'(PER) < int'(NTOT)) begin
            vi = (k - 2) / int'(PER);
            v  = exp_vec[vi];
            n_cmp++;
            if ({bus.dut_a, bus.dut_b, bus.dut_cin} !== v) begin
               n_bad++;
               $display("FAIL %s operands[%0d]: got %h want %h", name, vi,
                        {bus.dut_a, bus.dut_b, bus.dut_cin}, v);
            end
`ifdef ADDER_BIST_CORNER_EN
            if (vi == 2 && fault_mode == 0) begin
               n_cmp++;
               if ({bus.dut_cout, bus.dut_s} !== 17'h1FFFF) begin
                  n_bad++;
                  $display("FAIL %s corner2_sum: got %h want 1ffff", name, {bus.dut_cout, bus.dut_s});
               end
            end
`endif
         end
         if (glitch && k < int'(PER * NTOT) - 1) bus.start = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         k++;
         bus.start = 1'b0;
         if (bus.busy === 1'b1) busy_cycles++;
         else finished = 1'b1;
      end
      n_cmp++;
      if (!finished) begin
         n_bad++;
         $display("FAIL %s timeout: busy still high after %0d cycles, want done", name, k);
      end
      n_cmp++;
      if (busy_cycles != int'(PER * NTOT)) begin
         n_bad++;
         $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cycles, PER * NTOT);
      end
      hold = $urandom_range(0, 4);
      repeat (hold) @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pass !== (exp_err == 0)) begin
         n_bad++;
         $display("FAIL %s status: done=%b busy=%b pass=%b, want done=1 busy=0 pass=%b",
                  name, bus.done, bus.busy, bus.pass, exp_err == 0);
      end
      n_cmp++;
      if (bus.err_count !== 16'(exp_err)) begin
         n_bad++;
         $display("FAIL %s err_count: got %0d want %0d", name, bus.err_count, exp_err);
      end
      n_cmp++;
      if (bus.fail_vec !== exp_fail) begin
         n_bad++;
         $display("FAIL %s fail_vec: got %h want %h", name, bus.fail_vec, exp_fail);
      end
      n_cmp++;
      if ({bus.dut_a, bus.dut_b, bus.dut_cin} !== exp_vec[NTOT-1]) begin
         n_bad++;
         $display("FAIL %s held_operands: got %h want %h", name,
                  {bus.dut_a, bus.dut_b, bus.dut_cin}, exp_vec[NTOT-1]);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.done, bus.pass} !== 3'b000 || bus.err_count !== 16'd0 ||
          bus.fail_vec !== 33'd0 || {bus.dut_a, bus.dut_b, bus.dut_cin} !== 33'd0) begin
         n_bad++;
         $display("FAIL reset_state: busy=%b done=%b pass=%b err=%h fail=%h ops=%h, want all zero",
                  bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_vec,
                  {bus.dut_a, bus.dut_b, bus.dut_cin});
      end
      rst = 1'b0;
      repeat ($urandom_range(2, 10)) @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: busy=%b done=%b, want 0 0 without start", bus.busy, bus.done);
      end
   endtask

   task automatic test_correct_adder();
      fault_mode = 0;
      run_and_check("correct", 1'b0);
   endtask

   task automatic test_s0_stuck();
      fault_mode = 1;
      run_and_check("s0_stuck", 1'b0);
   endtask

   task automatic test_cout_inverted();
      fault_mode = 2;
      run_and_check("cout_inv", 1'b0);
      n_cmp++;
      if (bus.err_count !== 16'(NTOT)) begin
         n_bad++;
         $display("FAIL cout_inv_all: got err_count=%0d want %0d", bus.err_count, NTOT);
      end
`ifndef ADDER_BIST_CORNER_EN
      n_cmp++;
      if (bus.fail_vec !== {16'hACE1, 16'h1D2C, 1'b0}) begin
         n_bad++;
         $display("FAIL cout_inv_first: got fail_vec=%h want %h", bus.fail_vec, {16'hACE1, 16'h1D2C, 1'b0});
      end
`endif
   endtask

   task automatic test_reset_mid_run();
      fault_mode = 2;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      // now just past the start edge; wait to the 5th vector's WAIT phase
      repeat (PER * 4 + 1) @(negedge clk);
      n_cmp++;
      if (bus.err_count !== 16'd4 || bus.busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midrun_pre: err_count=%0d busy=%b, want 4 1", bus.err_count, bus.busy);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.err_count !== 16'd0 || bus.dut_a !== 16'd0 ||
          bus.done !== 1'b0 || bus.fail_vec !== 33'd0) begin
         n_bad++;
         $display("FAIL midrun_reset: busy=%b err=%h dut_a=%h done=%b fail=%h, want all zero",
                  bus.busy, bus.err_count, bus.dut_a, bus.done, bus.fail_vec);
      end
      @(negedge clk);
      rst = 1'b0;
      fault_mode = 0;
      run_and_check("after_reset", 1'b0);
   endtask

   task automatic test_back_to_back();
      fault_mode = 0;
      run_and_check("b2b_first", 1'b1);
      run_and_check("b2b_second", 1'b1);
   endtask

   task automatic test_random_runs();
      for (int r = 0; r < 5; r++) begin
         fault_mode = $urandom_range(0, 3);
         fault_bit  = $urandom_range(0, 16);
         repeat ($urandom_range(0, 6)) @(negedge clk);
         run_and_check($sformatf("random%0d_m%0d_b%0d", r, fault_mode, fault_bit), 1'b1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      test_reset();
      test_correct_adder();
      test_s0_stuck();
      test_cout_inverted();
      test_reset_mid_run();
      test_back_to_back();
      test_random_runs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
